mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/edge_rise.sv | 29 ++
 rtl/mult_seq.sv | 121 ++++++++++++
 tb/tb_mult_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared state encoding and counter sizing for mult_seq
//
// Purpose : FSM state constants (WAIT_A, WAIT_B, RUN, DONE) and the
//           step-counter width function used by mult_seq.
// Ports   : none (package).
package mult_seq_pkg;

  localparam logic [1:0] WAIT_A = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - registered rising-edge detector for a level input
//
// Purpose : flags the clock edge where i_sig is high and was low on the
//           previous edge. History is cleared by reset, so a signal that is
//           already high when reset releases counts as one rising edge.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           i_sig  - level input sampled every edge
//           o_rise - high when this edge is a rising edge of i_sig
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add multiplier loaded from a button/switch pair
//
// Purpose : first load event captures multiplicand A from sw, second captures
//           multiplier B and starts WIDTH shift-add steps; the product is then
//           published on ouput with a one-cycle done pulse.
//           Macro MULT_SIGNED_EN selects two's-complement arithmetic
//           (default: unsigned).
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           btn   - load strobe, level-sampled
//           sw    - operand value [WIDTH-1:0]
//           ouput - registered product [2*WIDTH-1:0]
//           busy  - high while in RUN
//           done  - one-cycle pulse when ouput updates
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic [WIDTH-1:0]   sw,
  output logic [2*WIDTH-1:0] ouput,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_out;
  logic               r_done;

  logic               w_load;
  logic               w_last;
  logic               w_sub;
  logic [2*WIDTH-1:0] w_mcand_ext;

  edge_rise u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (btn),
    .o_rise (w_load)
  );

  assign w_last = (r_cnt == LAST_STEP);

`ifdef MULT_SIGNED_EN
  assign w_mcand_ext = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  // The multiplier's top bit has weight -2^(WIDTH-1), so its partial product
  // is subtracted. r_b has been shifted down, so r_b[0] is that sign bit here.
  assign w_sub       = w_last;
`else
  assign w_mcand_ext = {{WIDTH{1'b0}}, r_a};
  assign w_sub       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        WAIT_A: begin
          if (w_load) begin
            r_a     <= sw;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_load) begin
            r_b     <= sw;
            r_mcand <= w_mcand_ext;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // One partial product per cycle: multiplicand walks left,
          // multiplier walks right so its current bit is always r_b[0].
          if (r_b[0]) begin
            r_acc <= w_sub ? (r_acc - r_mcand) : (r_acc + r_mcand);
          end
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Publishing only here keeps partial sums off ouput.
          r_out   <= r_acc;
          r_done  <= 1'b1;
          r_state <= WAIT_A;
        end
        default: r_state <= WAIT_A;
      endcase
    end
  end

  assign ouput = r_out;
  assign done  = r_done;
  assign busy  = (r_state == RUN);

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq (WIDTH 8 and 16 instances)
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic [7:0]  sw;
  logic [15:0] ouput;
  logic        busy;
  logic        done;

  logic        btn16;
  logic [15:0] sw16;
  logic [31:0] ouput16;
  logic        busy16;
  logic        done16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .sw    (sw),
    .ouput (ouput),
    .busy  (busy),
    .done  (done)
  );

  mult_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn16),
    .sw    (sw16),
    .ouput (ouput16),
    .busy  (busy16),
    .done  (done16)
  );

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {8'd0, a} * {8'd0, b};
`endif
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {16'd0, a} * {16'd0, b};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load A then B, then wait for done. Reports product, edges from B capture
  // to done, cycles busy was seen high, and whether ouput held meanwhile.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] got, output int lat,
                      output int bsy, output bit held);
    logic [15:0] prev;
    sw = a; btn = 1'b1; tick();
    btn = 1'b0; tick();
    sw = b; btn = 1'b1; tick();
    btn = 1'b0;
    prev = ouput;
    held = 1'b1;
    bsy  = busy ? 1 : 0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      lat = i;
      if (done) break;
      bsy += busy ? 1 : 0;
      if (ouput !== prev) held = 1'b0;
    end
    got = ouput;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; sw = '0; btn16 = 1'b0; sw16 = '0;
    tick(); tick();
    n_cmp++;
    if (ouput !== 16'd0) begin n_bad++; $display("FAIL reset_ouput got=%h want=0000", ouput); end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    n_cmp++;
    if (ouput16 !== 32'd0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      n_bad++; $display("FAIL reset_w16 ouput=%h busy=%b done=%b want zeros", ouput16, busy16, done16);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] got; int lat; int bsy; bit held;
    run8(8'd2, 8'd3, got, lat, bsy, held);
    n_cmp++;
    if (got !== 16'd6) begin n_bad++; $display("FAIL basic_2x3 got=%0d want=6", got); end
    n_cmp++;
    if (lat != 9) begin n_bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
    n_cmp++;
    if (bsy != 8) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bsy); end
    n_cmp++;
    if (!held) begin n_bad++; $display("FAIL basic_no_partial got=changed want=held"); end
    tick();
    n_cmp++;
    if (done !== 1'b0 || ouput !== 16'd6) begin
      n_bad++; $display("FAIL basic_pulse_hold done=%b ouput=%0d want 0 6", done, ouput);
    end
  endtask

  task automatic test_corners();
    logic [15:0] got; int lat; int bsy; bit held;
    run8(8'd255, 8'd255, got, lat, bsy, held);
    n_cmp++;
`ifdef MULT_SIGNED_EN
    if (got !== 16'h0001) begin n_bad++; $display("FAIL corner_max got=%h want=0001", got); end
`else
    if (got !== 16'hFE01) begin n_bad++; $display("FAIL corner_max got=%h want=fe01", got); end
`endif
    run8(8'd0, 8'd200, got, lat, bsy, held);
    n_cmp++;
    if (got !== 16'd0) begin n_bad++; $display("FAIL corner_zero got=%h want=0000", got); end
    n_cmp++;
    if (!held) begin n_bad++; $display("FAIL corner_hold got=changed want=held"); end
  endtask

  task automatic test_signed();
`ifdef MULT_SIGNED_EN
    logic [15:0] got; int lat; int bsy; bit held;
    run8(8'hFF, 8'hFF, got, lat, bsy, held);
    n_cmp++;
    if (got !== 16'h0001) begin n_bad++; $display("FAIL signed_m1xm1 got=%h want=0001", got); end
    run8(8'h80, 8'h7F, got, lat, bsy, held);
    n_cmp++;
    if (got !== 16'hC080) begin n_bad++; $display("FAIL signed_m128x127 got=%h want=c080", got); end
    n_cmp++;
    if (lat != 9) begin n_bad++; $display("FAIL signed_latency got=%0d want=9", lat); end
`endif
  endtask

  task automatic test_random();
    logic [15:0] got; int lat; int bsy; bit held;
    logic [7:0] a; logic [7:0] b;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      run8(a, b, got, lat, bsy, held);
      n_cmp++;
      if (got !== ref8(a, b) || lat != 9) begin
        n_bad++;
        $display("FAIL random_%0d a=%h b=%h got=%h lat=%0d want=%h lat=9", i, a, b, got, lat, ref8(a, b));
      end
    end
  endtask

  task automatic test_btn_hold();
    logic [7:0] a; logic [7:0] b;
    a = 8'($urandom); b = 8'($urandom);
    sw = a; btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sw = 8'($urandom);
    end
    btn = 1'b0; tick();
    sw = b; btn = 1'b1; tick();
    btn = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) break;
    end
    n_cmp++;
    if (done !== 1'b1 || ouput !== ref8(a, b)) begin
      n_bad++; $display("FAIL btn_hold done=%b got=%h want=%h", done, ouput, ref8(a, b));
    end
  endtask

  task automatic test_ignore_in_run();
    logic [7:0] a; logic [7:0] b;
    logic [15:0] got; int lat; int bsy; bit held;
    a = 8'($urandom); b = 8'($urandom);
    sw = a; btn = 1'b1; tick();
    btn = 1'b0; tick();
    sw = b; btn = 1'b1; tick();
    btn = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      // pulses land on RUN edges 2 and 4 and on the DONE edge 9
      btn = (k == 2 || k == 4 || k == 9);
      sw  = 8'($urandom);
      tick();
      lat = k;
      if (done) break;
    end
    btn = 1'b0; tick();
    n_cmp++;
    if (ouput !== ref8(a, b) || lat != 9) begin
      n_bad++; $display("FAIL ignore_run got=%h lat=%0d want=%h lat=9", ouput, lat, ref8(a, b));
    end
    a = 8'($urandom); b = 8'($urandom);
    run8(a, b, got, lat, bsy, held);
    n_cmp++;
    if (got !== ref8(a, b) || lat != 9) begin
      n_bad++; $display("FAIL ignore_followup got=%h lat=%0d want=%h lat=9", got, lat, ref8(a, b));
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got; int lat; int bsy; bit held;
    run8(8'd2, 8'd3, got, lat, bsy, held);
    n_cmp++;
    if (got !== 16'd6) begin n_bad++; $display("FAIL areset_prior got=%0d want=6", got); end
    sw = 8'd5; btn = 1'b1; tick();
    btn = 1'b0; tick();
    sw = 8'd11; btn = 1'b1; tick();
    btn = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    sw = 8'd7; btn = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ouput !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL areset_immediate ouput=%h busy=%b done=%b want 0 0 0", ouput, busy, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    btn = 1'b0; tick();
    sw = 8'd9; btn = 1'b1; tick();
    btn = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      lat = i;
      if (done) break;
    end
    n_cmp++;
    if (ouput !== 16'd63 || lat != 9) begin
      n_bad++; $display("FAIL areset_7x9 got=%0d lat=%0d want=63 lat=9", ouput, lat);
    end
  endtask

  task automatic test_wide();
    int lat; int bsy;
    logic [15:0] a; logic [15:0] b;
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 16'hFFFF : 16'($urandom);
      b = (t == 0) ? 16'h0002 : 16'($urandom);
      sw16 = a; btn16 = 1'b1; tick();
      btn16 = 1'b0; tick();
      sw16 = b; btn16 = 1'b1; tick();
      btn16 = 1'b0;
      bsy = busy16 ? 1 : 0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
        tick();
        lat = i;
        if (done16) break;
        bsy += busy16 ? 1 : 0;
      end
      n_cmp++;
      if (ouput16 !== ref16(a, b) || lat != 17 || bsy != 16) begin
        n_bad++;
        $display("FAIL wide_%0d a=%h b=%h got=%h lat=%0d busy=%0d want=%h lat=17 busy=16",
                 t, a, b, ouput16, lat, bsy, ref16(a, b));
      end
    end
`ifndef MULT_SIGNED_EN
    n_cmp++;
    if (ref16(16'hFFFF, 16'h0002) !== 32'h0001FFFE) begin
      n_bad++; $display("FAIL wide_model got=%h want=0001fffe", ref16(16'hFFFF, 16'h0002));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_signed();
    test_random();
    test_btn_hold();
    test_ignore_in_run();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
